// File: rtl/parking_gate_arbiter.sv
// Shared barrier-gate arbiter for the entry and exit lanes.
// Grants the gate to one lane at a time, sequences open/pass/close phases,
// and keeps the authoritative occupancy count against lot capacity.
// Build option: define EXIT_PRIORITY_EN to make exit win whenever both lanes
// are eligible; otherwise arbitration is round-robin on the last lane served.
module parking_gate_arbiter #(
    parameter int unsigned CAPACITY     = 12,
    parameter int unsigned CNT_W        = 4,
    parameter int unsigned OPEN_CYCLES  = 8,
    parameter int unsigned PASS_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             entry_req,
    input  logic             exit_req,
    input  logic             car_passed,
    output logic             entry_grant,
    output logic             exit_grant,
    output logic             gate_open,
    output logic             lot_full,
    output logic [CNT_W-1:0] occupancy,
    output logic             timeout_err
);

    // One phase timer shared by opening, passing and closing.
    localparam int unsigned TMR_MAX = (PASS_TIMEOUT > OPEN_CYCLES) ? PASS_TIMEOUT : OPEN_CYCLES;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] OPEN_LAST = TMR_W'(OPEN_CYCLES - 1);
    localparam logic [TMR_W-1:0] PASS_LAST = TMR_W'(PASS_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CAP       = CNT_W'(CAPACITY);

    typedef enum logic [1:0] {StIdle, StOpening, StPassing, StClosing} state_e;

    state_e           state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             owner_entry_q, owner_entry_d;  // lane currently holding the gate
    logic             last_entry_q, last_entry_d;    // 1: entry was served last
    logic [CNT_W-1:0] occ_q, occ_d;
    logic             timeout_q, timeout_d;
    logic             entry_elig, exit_elig, pick_entry;

    // Lane eligibility and arbitration between two eligible lanes.
    always_comb begin
        entry_elig = entry_req && (occ_q < CAP);
        exit_elig  = exit_req && (occ_q != '0);
`ifdef EXIT_PRIORITY_EN
        pick_entry = entry_elig && !exit_elig;
`else
        pick_entry = entry_elig && (!exit_elig || !last_entry_q);
`endif
    end

    // Next-state logic for the gate sequence, timer and occupancy.
    always_comb begin
        state_d       = state_q;
        tmr_d         = tmr_q;
        owner_entry_d = owner_entry_q;
        last_entry_d  = last_entry_q;
        occ_d         = occ_q;
        timeout_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (entry_elig || exit_elig) begin
                    state_d       = StOpening;
                    owner_entry_d = pick_entry;
                    tmr_d         = '0;
                end
            end
            StOpening: begin
                if (tmr_q == OPEN_LAST) begin
                    state_d = StPassing;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            StPassing: begin
                if (car_passed) begin
                    occ_d        = owner_entry_q ? occ_q + 1'b1 : occ_q - 1'b1;
                    last_entry_d = owner_entry_q;
                    state_d      = StClosing;
                    tmr_d        = '0;
                end else if (tmr_q == PASS_LAST) begin
                    // Give up on this car; count stays untouched.
                    timeout_d    = 1'b1;
                    last_entry_d = owner_entry_q;
                    state_d      = StClosing;
                    tmr_d        = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            StClosing: begin
                if (tmr_q == OPEN_LAST) begin
                    state_d = StIdle;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers; reset is asynchronous and active-high on reset_n.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state_q       <= StIdle;
            tmr_q         <= '0;
            owner_entry_q <= 1'b0;
            last_entry_q  <= 1'b0;
            occ_q         <= '0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            tmr_q         <= tmr_d;
            owner_entry_q <= owner_entry_d;
            last_entry_q  <= last_entry_d;
            occ_q         <= occ_d;
            timeout_q     <= timeout_d;
        end
    end

    // Outputs decoded from registered state only.
    always_comb begin
        entry_grant = (state_q != StIdle) && owner_entry_q;
        exit_grant  = (state_q != StIdle) && !owner_entry_q;
        gate_open   = (state_q == StOpening) || (state_q == StPassing);
        lot_full    = (occ_q == CAP);
        occupancy   = occ_q;
        timeout_err = timeout_q;
    end

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Scoreboard bench for parking_gate_arbiter (default build, round-robin).
// Stimulus pushes one expected gate cycle per grant; a monitor measures each
// cycle on the DUT outputs and compares when the grant drops.
module tb_parking_gate_arbiter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       entry_req, exit_req, car_passed;
    logic       entry_grant, exit_grant, gate_open, lot_full, timeout_err;
    logic [3:0] occupancy;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int lane;     // 1 entry, 0 exit
        int open_n;   // cycles with gate_open high during the grant
        int close_n;  // cycles with grant high and gate_open low
        int to_n;     // timeout_err pulses during the grant
        int occ;      // occupancy once the grant drops
        int abort;    // 1 when the cycle is expected to be cut by reset
    } exp_t;

    exp_t exp_q[$];

    parking_gate_arbiter dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .entry_req   (entry_req),
        .exit_req    (exit_req),
        .car_passed  (car_passed),
        .entry_grant (entry_grant),
        .exit_grant  (exit_grant),
        .gate_open   (gate_open),
        .lot_full    (lot_full),
        .occupancy   (occupancy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: measures each grant period and scores it against the queue.
    bit in_cycle = 1'b0;
    int m_lane, m_open, m_close, m_to;
    always @(negedge clk) begin
        exp_t e;
        if (reset_n === 1'b1) begin
            if (in_cycle) begin
                check("pending on reset", exp_q.size(), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("abort expected", e.abort, 1);
                end
            end
            in_cycle = 1'b0;
        end else begin
            if (entry_grant && exit_grant) check("one-hot grant", 2, 1);
            if ((entry_grant || exit_grant) && !in_cycle) begin
                check("pending expectation", exp_q.size(), 1);
                in_cycle = 1'b1;
                m_lane   = int'(entry_grant);
                m_open   = 0;
                m_close  = 0;
                m_to     = 0;
            end
            if (entry_grant || exit_grant) begin
                if (int'(entry_grant) != m_lane) check("lane stable", int'(entry_grant), m_lane);
                m_open  += int'(gate_open);
                m_close += int'(!gate_open);
                m_to    += int'(timeout_err);
            end else if (in_cycle) begin
                in_cycle = 1'b0;
                if (exp_q.size() == 0) begin
                    check("expectation present", 0, 1);
                end else begin
                    e = exp_q.pop_front();
                    check("lane", m_lane, e.lane);
                    check("gate_open cycles", m_open, e.open_n);
                    check("closing cycles", m_close, e.close_n);
                    check("timeout pulses", m_to, e.to_n);
                    check("occupancy after", int'(occupancy), e.occ);
                end
            end
        end
    end

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(posedge clk);
            #1;
            if (!entry_grant && !exit_grant) done = 1'b1;
        end
        check("returned to idle", int'(done), 1);
    endtask

    // One gate cycle; delay = passing cycle of the car_passed pulse, 0 = never.
    task automatic run(input bit ent, input bit ex, input int lane, input int delay,
                       input int occ);
        exp_t e;
        @(negedge clk);
        entry_req = ent;
        exit_req  = ex;
        e = '{lane: lane, open_n: (delay > 0) ? 8 + delay : 8 + 64, close_n: 8,
              to_n: (delay > 0) ? 0 : 1, occ: occ, abort: 0};
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check("grant latency", int'(lane != 0 ? entry_grant : exit_grant), 1);
        check("gate_open at grant", int'(gate_open), 1);
        entry_req = 1'b0;
        exit_req  = 1'b0;
        if (delay > 0) begin
            repeat (7 + delay) @(posedge clk);
            #1;
            car_passed = 1'b1;
            @(posedge clk);
            #1;
            car_passed = 1'b0;
        end
        wait_idle();
    endtask

    // Hold a request that must not be granted.
    task automatic no_grant(input bit ent, input bit ex, input string name);
        int seen = 0;
        @(negedge clk);
        entry_req = ent;
        exit_req  = ex;
        repeat (20) begin
            @(negedge clk);
            seen += int'(entry_grant || exit_grant || gate_open);
        end
        entry_req = 1'b0;
        exit_req  = 1'b0;
        check(name, seen, 0);
    endtask

    initial begin
        exp_t e;
        reset_n    = 1'b1;
        entry_req  = 1'b0;
        exit_req   = 1'b0;
        car_passed = 1'b0;
        repeat (3) @(negedge clk);
        check("reset entry_grant", int'(entry_grant), 0);
        check("reset exit_grant", int'(exit_grant), 0);
        check("reset gate_open", int'(gate_open), 0);
        check("reset lot_full", int'(lot_full), 0);
        check("reset occupancy", int'(occupancy), 0);
        check("reset timeout_err", int'(timeout_err), 0);
        reset_n = 1'b0;

        no_grant(1'b0, 1'b1, "empty exit not granted");

        run(1'b1, 1'b0, 1, 3, 1);
        run(1'b1, 1'b0, 1, 1, 2);
        // Both eligible: alternate away from the last lane served (entry).
        run(1'b1, 1'b1, 0, 2, 1);
        run(1'b1, 1'b1, 1, 2, 2);
        run(1'b1, 1'b1, 0, 2, 1);
        run(1'b1, 1'b0, 1, 0, 1);

        // Stray car_passed while idle is ignored.
        @(negedge clk);
        car_passed = 1'b1;
        @(negedge clk);
        car_passed = 1'b0;
        @(negedge clk);
        check("idle car_passed ignored", int'(occupancy), 1);

        for (int n = 2; n <= 12; n++) run(1'b1, 1'b0, 1, 1, n);
        check("full occupancy", int'(occupancy), 12);
        check("lot_full at capacity", int'(lot_full), 1);
        no_grant(1'b1, 1'b0, "entry blocked when full");
        run(1'b0, 1'b1, 0, 1, 11);
        check("lot_full cleared", int'(lot_full), 0);

        // Reset in the middle of PASSING.
        @(negedge clk);
        entry_req = 1'b1;
        e = '{lane: 1, open_n: 0, close_n: 0, to_n: 0, occ: 0, abort: 1};
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        entry_req = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("in passing before reset", int'(gate_open && entry_grant), 1);
        reset_n = 1'b1;
        #1;
        check("mid reset entry_grant", int'(entry_grant), 0);
        check("mid reset gate_open", int'(gate_open), 0);
        check("mid reset occupancy", int'(occupancy), 0);
        check("mid reset timeout_err", int'(timeout_err), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("occupancy after release", int'(occupancy), 0);
        run(1'b1, 1'b0, 1, 2, 1);

        repeat (4) @(negedge clk);
        check("scoreboard drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
